// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package regfile_wb_arbiter_pkg;

  localparam int ADR_W  = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 1 << ADR_W;

  localparam logic [ADR_W-1:0] REG_ZERO = '0;

  // One register-file write: destination and value.
  typedef struct packed {
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  localparam int WB_REQ_W = $bits(wb_req_t);

  // Decode a register address into a one-hot register mask.
  function automatic logic [NREGS-1:0] reg_onehot(input logic [ADR_W-1:0] a);
    reg_onehot    = '0;
    reg_onehot[a] = 1'b1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle for the write-back arbiter: pipeline result, long-latency
// handshake, decode hazard check and the register-file write port.
interface regfile_wb_arbiter_if;
  import regfile_wb_arbiter_pkg::*;

  logic                pipe_valid;
  logic [ADR_W-1:0]    pipe_adrW;
  logic [DATA_W-1:0]   pipe_inW;
  logic                lng_issue;
  logic [ADR_W-1:0]    lng_issue_adr;
  logic                lng_valid;
  logic                lng_ready;
  logic [ADR_W-1:0]    lng_adrW;
  logic [DATA_W-1:0]   lng_inW;
  logic [ADR_W-1:0]    chk_adrA;
  logic [ADR_W-1:0]    chk_adrB;
  logic [ADR_W-1:0]    chk_adrD;
  logic                stall;
  logic [NREGS-1:0]    pending;
  logic [ADR_W-1:0]    adrW;
  logic                writeEn;
  logic [DATA_W-1:0]   inW;

  // Arbiter side.
  modport slave (
    input  pipe_valid, pipe_adrW, pipe_inW,
    input  lng_issue, lng_issue_adr,
    input  lng_valid, lng_adrW, lng_inW,
    input  chk_adrA, chk_adrB, chk_adrD,
    output lng_ready, stall, pending,
    output adrW, writeEn, inW
  );

  // Pipeline / execution-unit side.
  modport master (
    output pipe_valid, pipe_adrW, pipe_inW,
    output lng_issue, lng_issue_adr,
    output lng_valid, lng_adrW, lng_inW,
    output chk_adrA, chk_adrB, chk_adrD,
    input  lng_ready, stall, pending,
    input  adrW, writeEn, inW
  );

endinterface

// File: rtl/regfile_wb_arbiter_wb_sync_fifo.sv
// Small synchronous FIFO holding long-latency results until the write port
// is free. Pointers carry one extra wrap bit to tell full from empty.
module wb_sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign rd_data_o = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Pointer advance; reset discards all contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Entry storage; contents are meaningless until the pointers say otherwise.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: pipeline results take the write port
// with fixed priority; long-latency results are buffered and drained when
// the pipeline is idle. A pending scoreboard lets decode stall on hazards.
// Optional feature macro: WB_BYPASS_EN (idle-port long results skip the FIFO).
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int LNG_DEPTH = 2
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);

  wb_req_t          pipe_req, lng_req, head_req;
  wb_req_t          out_d, out_q;
  logic             we_d, we_q;
  logic             fifo_full, fifo_empty;
  logic             lng_acc, lng_keep, push, pop, bypass, clr_en;
  logic [NREGS-1:0] pend_d, pend_q, set_vec, clr_vec;

  assign pipe_req = '{adr: bus.pipe_adrW, data: bus.pipe_inW};
  assign lng_req  = '{adr: bus.lng_adrW,  data: bus.lng_inW};

  // Ready is derived from the registered full flag only; held low in reset.
  assign bus.lng_ready = ~fifo_full & ~rst;
  assign lng_acc       = bus.lng_valid & bus.lng_ready;
  assign lng_keep      = (bus.lng_adrW != REG_ZERO);
  assign push          = lng_acc & lng_keep & ~bypass;

  wb_sync_fifo #(
    .DEPTH (LNG_DEPTH),
    .WIDTH (WB_REQ_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .wr_data_i (lng_req),
    .pop_i     (pop),
    .rd_data_o (head_req),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Write-port arbitration: pipeline first, then buffered long results.
  always_comb begin
    we_d   = 1'b0;
    out_d  = out_q;
    pop    = 1'b0;
    bypass = 1'b0;
    clr_en = 1'b0;
    if (bus.pipe_valid) begin
      we_d  = 1'b1;
      out_d = pipe_req;
    end else if (!fifo_empty) begin
      we_d   = 1'b1;
      out_d  = head_req;
      pop    = 1'b1;
      clr_en = 1'b1;
    end
`ifdef WB_BYPASS_EN
    else if (lng_acc && lng_keep) begin
      we_d   = 1'b1;
      out_d  = lng_req;
      bypass = 1'b1;
      clr_en = 1'b1;
    end
`endif
  end

  // Scoreboard set/clear masks; set is applied after clear so it wins.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (bus.lng_issue && (bus.lng_issue_adr != REG_ZERO))
      set_vec = reg_onehot(bus.lng_issue_adr);
    if (clr_en)
      clr_vec = reg_onehot(out_d.adr);
  end

  assign pend_d[0] = 1'b0;
  for (genvar gi = 1; gi < NREGS; gi++) begin : g_pend
    assign pend_d[gi] = set_vec[gi] | (pend_q[gi] & ~clr_vec[gi]);
  end

  // Registered write port and scoreboard.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      out_q  <= '0;
      pend_q <= '0;
    end else begin
      we_q   <= we_d;
      out_q  <= out_d;
      pend_q <= pend_d;
    end
  end

  assign bus.writeEn = we_q;
  assign bus.adrW    = out_q.adr;
  assign bus.inW     = out_q.data;
  assign bus.pending = pend_q;
  assign bus.stall   = pend_q[bus.chk_adrA] | pend_q[bus.chk_adrB] |
                       pend_q[bus.chk_adrD];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter (also meaningful with WB_BYPASS_EN).
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int DEPTH = 2;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter #(.LNG_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Accepted results wait in a queue; the write port takes the pipeline
  // result if present, else the oldest queued result.
  wb_req_t     m_q[$];
  logic [31:0] m_pend = '0;
  logic        m_we   = 1'b0;
  logic [4:0]  m_adr  = '0;
  logic [31:0] m_data = '0;
  bit          m_init = 1'b0;

  always @(posedge clk) begin : model
    automatic bit      acc;
    automatic bit      used = 1'b0;
    automatic wb_req_t w;
    if (rst) begin
      m_q.delete();
      m_pend <= '0;
      m_we   <= 1'b0;
      m_adr  <= '0;
      m_data <= '0;
      m_init <= 1'b1;
    end else begin
      acc = bus.lng_valid && (m_q.size() < DEPTH);
      if (bus.pipe_valid) begin
        m_we <= 1'b1; m_adr <= bus.pipe_adrW; m_data <= bus.pipe_inW;
      end else if (m_q.size() > 0) begin
        w = m_q.pop_front();
        m_we <= 1'b1; m_adr <= w.adr; m_data <= w.data;
        m_pend[w.adr] <= 1'b0;
      end
`ifdef WB_BYPASS_EN
      else if (acc && bus.lng_adrW != 5'd0) begin
        m_we <= 1'b1; m_adr <= bus.lng_adrW; m_data <= bus.lng_inW;
        m_pend[bus.lng_adrW] <= 1'b0;
        used = 1'b1;
      end
`endif
      else begin
        m_we <= 1'b0;
      end
      if (acc && bus.lng_adrW != 5'd0 && !used)
        m_q.push_back('{adr: bus.lng_adrW, data: bus.lng_inW});
      if (bus.lng_issue && bus.lng_issue_adr != 5'd0)
        m_pend[bus.lng_issue_adr] <= 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_init) begin
      check("cyc_writeEn", {31'd0, bus.writeEn}, {31'd0, m_we});
      check("cyc_adrW",    {27'd0, bus.adrW},    {27'd0, m_adr});
      check("cyc_inW",     bus.inW,              m_data);
      check("cyc_pending", bus.pending,          m_pend);
      check("cyc_ready",   {31'd0, bus.lng_ready},
            {31'd0, (!rst && m_q.size() < DEPTH)});
      check("cyc_stall",   {31'd0, bus.stall},
            {31'd0, m_pend[bus.chk_adrA] | m_pend[bus.chk_adrB] | m_pend[bus.chk_adrD]});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  logic [4:0]  oa [3];
  logic [31:0] od [3];
  int          k;

  task automatic load_offer(input int idx);
    bus.lng_valid = 1'b1;
    bus.lng_adrW  = oa[idx];
    bus.lng_inW   = od[idx];
  endtask

  // One edge of long-result offering: advance when the handshake completes.
  task automatic step_offer();
    automatic bit acc = bus.lng_valid && bus.lng_ready;
    cyc();
    if (acc) begin
      k++;
      if (k < 3) load_offer(k);
      else bus.lng_valid = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.pipe_valid = 0; bus.pipe_adrW = 0; bus.pipe_inW = 0;
    bus.lng_issue = 0; bus.lng_issue_adr = 0;
    bus.lng_valid = 0; bus.lng_adrW = 0; bus.lng_inW = 0;
    bus.chk_adrA = 0; bus.chk_adrB = 0; bus.chk_adrD = 0;
    oa[0] = 5'd10; oa[1] = 5'd11; oa[2] = 5'd12;
    od[0] = 32'hA000_0000; od[1] = 32'hA111_1111; od[2] = 32'hA222_2222;

    // Reset
    cyc(); cyc();
    check("rst_writeEn", {31'd0, bus.writeEn}, 32'd0);
    check("rst_pending", bus.pending, 32'd0);
    check("rst_ready",   {31'd0, bus.lng_ready}, 32'd0);
    rst = 1'b0;
    #1 check("post_rst_ready", {31'd0, bus.lng_ready}, 32'd1);
    cyc();
    $display("reset checked");

    // Pipeline write, latency 1
    bus.pipe_valid = 1; bus.pipe_adrW = 5'd5; bus.pipe_inW = 32'hDEADBEEF;
    cyc();
    bus.pipe_valid = 0;
    check("pipe_we",   {31'd0, bus.writeEn}, 32'd1);
    check("pipe_adr",  {27'd0, bus.adrW}, 32'd5);
    check("pipe_data", bus.inW, 32'hDEADBEEF);
    cyc();
    check("pipe_we_off", {31'd0, bus.writeEn}, 32'd0);
    $display("pipeline write 5 <= deadbeef");

    // Issue, stall, long result
    bus.lng_issue = 1; bus.lng_issue_adr = 5'd9;
    cyc();
    bus.lng_issue = 0; bus.chk_adrA = 5'd9;
    #1 check("issue_stall", {31'd0, bus.stall}, 32'd1);
    check("issue_pend9", {31'd0, bus.pending[9]}, 32'd1);
    bus.lng_valid = 1; bus.lng_adrW = 5'd9; bus.lng_inW = 32'h1234;
    cyc();
    bus.lng_valid = 0;
`ifndef WB_BYPASS_EN
    check("lng_not_yet", {31'd0, bus.writeEn}, 32'd0);
    check("lng_still_stall", {31'd0, bus.stall}, 32'd1);
    cyc();
`endif
    check("lng_we",    {31'd0, bus.writeEn}, 32'd1);
    check("lng_adr",   {27'd0, bus.adrW}, 32'd9);
    check("lng_data",  bus.inW, 32'h1234);
    check("lng_pend9", {31'd0, bus.pending[9]}, 32'd0);
    check("lng_stall", {31'd0, bus.stall}, 32'd0);
    bus.chk_adrA = 0;
    cyc();
    check("lng_we_off", {31'd0, bus.writeEn}, 32'd0);
    $display("long write 9 <= 1234");

    // Backpressure while the pipeline owns the port
    for (int i = 0; i < 3; i++) begin
      bus.lng_issue = 1; bus.lng_issue_adr = oa[i];
      cyc();
    end
    bus.lng_issue = 0;
    k = 0;
    load_offer(0);
    for (int i = 0; i < 6; i++) begin
      bus.pipe_valid = 1; bus.pipe_adrW = 5'(20 + i); bus.pipe_inW = 32'h5000 + 32'(i);
      step_offer();
    end
    check("bp_accepted", k, 32'd2);
    check("bp_ready", {31'd0, bus.lng_ready}, 32'd0);
    bus.pipe_valid = 0;
    step_offer();
    check("drain0_adr",  {27'd0, bus.adrW}, 32'd10);
    check("drain0_data", bus.inW, 32'hA000_0000);
    check("drain0_acc",  k, 32'd2);
    step_offer();
    check("drain1_adr",  {27'd0, bus.adrW}, 32'd11);
    check("drain1_data", bus.inW, 32'hA111_1111);
    check("drain1_acc",  k, 32'd3);
    step_offer();
    check("drain2_we",   {31'd0, bus.writeEn}, 32'd1);
    check("drain2_adr",  {27'd0, bus.adrW}, 32'd12);
    check("drain2_pend", bus.pending, 32'd0);
    cyc();
    check("drain_idle", {31'd0, bus.writeEn}, 32'd0);
    $display("backpressure and in-order drain");

    // Register zero: no pending, no write
    bus.lng_issue = 1; bus.lng_issue_adr = 5'd0;
    bus.lng_valid = 1; bus.lng_adrW = 5'd0; bus.lng_inW = 32'h55;
    #1 check("z_ready_pre", {31'd0, bus.lng_ready}, 32'd1);
    cyc();
    bus.lng_issue = 0; bus.lng_valid = 0;
    check("z_pending", bus.pending, 32'd0);
    check("z_ready",   {31'd0, bus.lng_ready}, 32'd1);
    check("z_we",      {31'd0, bus.writeEn}, 32'd0);
    cyc();
    check("z_we2",     {31'd0, bus.writeEn}, 32'd0);
    $display("register zero ignored");

    // Same-edge clear and set of register 7
    bus.lng_issue = 1; bus.lng_issue_adr = 5'd7;
    cyc();
    bus.lng_issue = 0;
    bus.lng_valid = 1; bus.lng_adrW = 5'd7; bus.lng_inW = 32'h77;
`ifdef WB_BYPASS_EN
    bus.lng_issue = 1;
`endif
    cyc();
    bus.lng_valid = 0;
`ifndef WB_BYPASS_EN
    bus.lng_issue = 1;
    cyc();
`endif
    bus.lng_issue = 0;
    check("sc_we",    {31'd0, bus.writeEn}, 32'd1);
    check("sc_adr",   {27'd0, bus.adrW}, 32'd7);
    check("sc_pend7", {31'd0, bus.pending[7]}, 32'd1);
    $display("set wins over clear on reg 7");

    // Reset with buffered results and pending bits
    bus.pipe_valid = 1; bus.pipe_adrW = 5'd1; bus.pipe_inW = 32'h1;
    bus.lng_issue = 1; bus.lng_issue_adr = 5'd3;
    cyc();
    bus.lng_issue_adr = 5'd4;
    bus.lng_valid = 1; bus.lng_adrW = 5'd3; bus.lng_inW = 32'h333;
    cyc();
    bus.lng_issue = 0;
    bus.lng_adrW = 5'd4; bus.lng_inW = 32'h444;
    cyc();
    bus.lng_valid = 0;
    check("rr_full",    {31'd0, bus.lng_ready}, 32'd0);
    check("rr_pending", bus.pending, 32'h0000_0098);
    bus.chk_adrD = 5'd4;
    #1 check("rr_stallD", {31'd0, bus.stall}, 32'd1);
    bus.chk_adrD = 5'd0;
    rst = 1; bus.pipe_valid = 0;
    #1 check("rr_ready_in_rst", {31'd0, bus.lng_ready}, 32'd0);
    cyc();
    check("rr_we",      {31'd0, bus.writeEn}, 32'd0);
    check("rr_pend",    bus.pending, 32'd0);
    check("rr_ready",   {31'd0, bus.lng_ready}, 32'd0);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("rr_no_stale", {31'd0, bus.writeEn}, 32'd0);
    end
    check("rr_ready_after", {31'd0, bus.lng_ready}, 32'd1);
    $display("mid-operation reset discards state");

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
